// File: rtl/euler_step_sequencer.sv
// Euler integration step sequencer: on an accepted start, loops derivative request/ack and
// state-commit strobes over [t0, t_end) and returns a single final_done pulse per run.
//
// state    | meaning
// IDLE     | waiting for start, final values held on t_cur/step_cnt
// WAIT_ACK | deriv_req asserted, timing out after ACK_TIMEOUT cycles
// UPDATE   | one-cycle commit: update_en, t_cur += h, step_cnt += 1
// DONE     | run finished, final_done follows on the next cycle
module euler_step_sequencer #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              rst_sync,
    input  logic              start,
    input  logic [DATA_W-1:0] t0_in,
    input  logic [DATA_W-1:0] t_end_in,
    input  logic [DATA_W-1:0] h_in,
    input  logic [CNT_W-1:0]  step_max_in,
    output logic              deriv_req,
    input  logic              deriv_ack,
    output logic              update_en,
    output logic [DATA_W-1:0] t_cur,
    output logic [CNT_W-1:0]  step_cnt,
    output logic              busy,
    output logic              final_done,
    output logic              err
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        UPDATE   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] h_q, t_end_q;
    logic [CNT_W-1:0]  step_max_q;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic [DATA_W:0]   sum_full;
    logic              sum_carry;
    logic [DATA_W-1:0] sum;
    logic [CNT_W-1:0]  step_inc;
    logic              start_ok;
    logic              timed_out;

    logic              deriv_req_d, update_en_d, busy_d, final_done_d, err_d;
    logic [DATA_W-1:0] t_cur_d;
    logic [CNT_W-1:0]  step_cnt_d;

    assign sum_full  = {1'b0, t_cur} + {1'b0, h_q};
    assign sum_carry = sum_full[DATA_W];
    assign sum       = sum_full[DATA_W-1:0];
    assign step_inc  = step_cnt + CNT_W'(1);
    assign start_ok  = (state_q == IDLE) && start;
    assign timed_out = (state_q == WAIT_ACK) && !deriv_ack && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            state_q <= IDLE;
        else if (rst_sync)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((t0_in >= t_end_in) || (step_max_in == '0))
                        state_d = DONE;
                    else
                        state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (deriv_ack)
                    state_d = UPDATE;
                else if (to_cnt_q == TO_LAST)
                    state_d = DONE;
            end
            UPDATE: begin
                if (sum_carry || (sum >= t_end_q) || (step_inc == step_max_q))
                    state_d = DONE;
                else
                    state_d = WAIT_ACK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so deriv_req/update_en/busy line up
    // with the state they describe; final_done trails DONE by one cycle.
    always_comb begin
        deriv_req_d  = (state_d == WAIT_ACK);
        update_en_d  = (state_d == UPDATE);
        busy_d       = (state_d != IDLE);
        final_done_d = (state_q == DONE);
        to_cnt_d     = '0;
        t_cur_d      = t_cur;
        step_cnt_d   = step_cnt;
        err_d        = err;
        if ((state_q == WAIT_ACK) && (state_d == WAIT_ACK))
            to_cnt_d = to_cnt_q + TO_W'(1);
        if (start_ok) begin
            t_cur_d    = t0_in;
            step_cnt_d = '0;
            err_d      = 1'b0;
        end
        if (timed_out)
            err_d = 1'b1;
        if (state_q == UPDATE) begin
            step_cnt_d = step_inc;
            if (sum_carry) begin
                t_cur_d = '1;
                err_d   = 1'b1;
            end else begin
                t_cur_d = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            deriv_req  <= 1'b0;
            update_en  <= 1'b0;
            busy       <= 1'b0;
            final_done <= 1'b0;
            err        <= 1'b0;
            t_cur      <= '0;
            step_cnt   <= '0;
            to_cnt_q   <= '0;
            h_q        <= '0;
            t_end_q    <= '0;
            step_max_q <= '0;
        end else if (rst_sync) begin
            deriv_req  <= 1'b0;
            update_en  <= 1'b0;
            busy       <= 1'b0;
            final_done <= 1'b0;
            err        <= 1'b0;
            t_cur      <= '0;
            step_cnt   <= '0;
            to_cnt_q   <= '0;
            h_q        <= '0;
            t_end_q    <= '0;
            step_max_q <= '0;
        end else begin
            deriv_req  <= deriv_req_d;
            update_en  <= update_en_d;
            busy       <= busy_d;
            final_done <= final_done_d;
            err        <= err_d;
            t_cur      <= t_cur_d;
            step_cnt   <= step_cnt_d;
            to_cnt_q   <= to_cnt_d;
            if (start_ok) begin
                h_q        <= h_in;
                t_end_q    <= t_end_in;
                step_max_q <= step_max_in;
            end
        end
    end

endmodule
